// File: rtl/bsg_nonsynth_manycore_tag_sequencer.sv
// Shares one bsg_tag serial line among several requesters: plays the tag-master
// init sequence after reset, then round-robin serializes packets LSB first.
module bsg_nonsynth_manycore_tag_sequencer #(
   parameter int unsigned num_requesters_p    = 2,
   parameter int unsigned num_clients_p       = 4,
   parameter int unsigned max_payload_width_p = 1,
   parameter int unsigned init_ones_p         = 16,
   parameter int unsigned init_zeros_p        = 16,
   localparam int unsigned lg_clients_lp = (num_clients_p > 1) ? $clog2(num_clients_p) : 1,
   localparam int unsigned lg_len_lp     = $clog2(max_payload_width_p + 1)
) (
   input  logic                                          clk_i,
   input  logic                                          reset_i,
   input  logic [num_requesters_p-1:0]                   v_i,
   input  logic [num_requesters_p*lg_clients_lp-1:0]     client_id_i,
   input  logic [num_requesters_p-1:0]                   data_not_reset_i,
   input  logic [num_requesters_p*lg_len_lp-1:0]         len_i,
   input  logic [num_requesters_p*max_payload_width_p-1:0] payload_i,
   output logic [num_requesters_p-1:0]                   yumi_o,
   output logic                                          tag_data_o,
   output logic                                          init_done_o,
   output logic                                          busy_o
);

   localparam int unsigned lg_req_lp   = (num_requesters_p > 1) ? $clog2(num_requesters_p) : 1;
   localparam int unsigned hdr_len_lp  = 2 + lg_clients_lp + lg_len_lp;
   localparam int unsigned pkt_max_lp  = hdr_len_lp + max_payload_width_p;
   localparam int unsigned init_max_lp = (init_ones_p > init_zeros_p) ? init_ones_p : init_zeros_p;
   localparam int unsigned cnt_max_lp  = (init_max_lp > pkt_max_lp) ? init_max_lp : pkt_max_lp;
   localparam int unsigned cnt_w_lp    = $clog2(cnt_max_lp + 1);

   typedef enum logic [1:0] {
      e_init_ones,
      e_init_zeros,
      e_idle,
      e_send
   } state_e;

   state_e                  state_q, state_d;
   logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
   logic [pkt_max_lp-1:0]   shift_q, shift_d;
   logic [lg_req_lp-1:0]    ptr_q, ptr_d;
   logic                    init_done_q, init_done_d;

   logic                           grant_v;
   logic [lg_req_lp-1:0]           grant_idx;
   logic [lg_clients_lp-1:0]       id_sel;
   logic                           dnr_sel;
   logic [lg_len_lp-1:0]           len_sel;
   logic [lg_len_lp-1:0]           len_clamp;
   logic [max_payload_width_p-1:0] payload_sel;
   logic                           len_bad;
   logic                           id_bad;

   // Round-robin: first valid requester at or after the pointer, wrapping.
   always_comb begin
      int unsigned cand;
      cand      = 0;
      grant_v   = 1'b0;
      grant_idx = '0;
      for (int unsigned i = 0; i < num_requesters_p; i++) begin
         cand = 32'(ptr_q) + i;
         if (cand >= num_requesters_p) cand = cand - num_requesters_p;
         for (int unsigned j = 0; j < num_requesters_p; j++) begin
            if (!grant_v && (cand == j) && v_i[j]) begin
               grant_v   = 1'b1;
               grant_idx = lg_req_lp'(j);
            end
         end
      end
   end

   // Field mux of the granted requester; oversize lengths are clamped.
   always_comb begin
      id_sel      = '0;
      dnr_sel     = 1'b0;
      len_sel     = '0;
      payload_sel = '0;
      for (int unsigned j = 0; j < num_requesters_p; j++) begin
         if (grant_idx == lg_req_lp'(j)) begin
            id_sel      = client_id_i[j*lg_clients_lp +: lg_clients_lp];
            dnr_sel     = data_not_reset_i[j];
            len_sel     = len_i[j*lg_len_lp +: lg_len_lp];
            payload_sel = payload_i[j*max_payload_width_p +: max_payload_width_p];
         end
      end
      len_bad   = 32'(len_sel) > max_payload_width_p;
      id_bad    = 32'(id_sel) >= num_clients_p;
      len_clamp = len_bad ? lg_len_lp'(max_payload_width_p) : len_sel;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= e_init_ones;
         cnt_q       <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         init_done_q <= init_done_d;
      end
   end

   // Illegal requests are reported at acceptance; the packet still goes out.
   always_ff @(posedge clk_i) begin
      if (!reset_i && (state_q == e_idle) && grant_v) begin
         if (len_bad) $error("tag_sequencer: len %0d exceeds max payload width %0d",
                             len_sel, max_payload_width_p);
         if (id_bad)  $error("tag_sequencer: client_id %0d out of range", id_sel);
      end
   end

   // In SEND, cnt_q holds the number of bits still to follow the current one.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      init_done_d = init_done_q;
      case (state_q)
         e_init_ones: begin
            if (cnt_q == cnt_w_lp'(init_ones_p - 1)) begin
               cnt_d   = '0;
               state_d = e_init_zeros;
            end else begin
               cnt_d = cnt_q + cnt_w_lp'(1);
            end
         end
         e_init_zeros: begin
            if (cnt_q == cnt_w_lp'(init_zeros_p - 1)) begin
               cnt_d       = '0;
               state_d     = e_idle;
               init_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + cnt_w_lp'(1);
            end
         end
         e_idle: begin
            if (grant_v) begin
               state_d = e_send;
               shift_d = {payload_sel, len_clamp, dnr_sel, id_sel, 1'b1};
               cnt_d   = cnt_w_lp'(hdr_len_lp - 1) + cnt_w_lp'(len_clamp);
               ptr_d   = (32'(grant_idx) == num_requesters_p - 1) ? '0
                                                                   : grant_idx + lg_req_lp'(1);
            end
         end
         e_send: begin
            if (cnt_q == '0) begin
               state_d = e_idle;
            end else begin
               shift_d = shift_q >> 1;
               cnt_d   = cnt_q - cnt_w_lp'(1);
            end
         end
         default: state_d = e_init_ones;
      endcase
   end

   // Outputs are forced to their reset values while reset_i is high.
   always_comb begin
      yumi_o      = '0;
      tag_data_o  = 1'b0;
      busy_o      = 1'b1;
      init_done_o = 1'b0;
      if (!reset_i) begin
         busy_o      = (state_q != e_idle);
         init_done_o = init_done_q;
         case (state_q)
            e_init_ones: tag_data_o = 1'b1;
            e_send:      tag_data_o = shift_q[0];
            e_idle: begin
               for (int unsigned j = 0; j < num_requesters_p; j++) begin
                  if (grant_v && (grant_idx == lg_req_lp'(j))) yumi_o[j] = 1'b1;
               end
            end
            default: tag_data_o = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_bsg_nonsynth_manycore_tag_sequencer.sv
// Scoreboard bench: stimulus queues expected grants and serial packets, a
// negedge monitor deserializes tag_data_o and checks yumi_o against them.
module tb_bsg_nonsynth_manycore_tag_sequencer;

   localparam int unsigned LG_CLIENTS = 2;
   localparam int unsigned LG_LEN     = 1;
   localparam int unsigned HDR        = 2 + LG_CLIENTS + LG_LEN;

   logic       clk;
   logic       reset_i;
   logic [1:0] v_i;
   logic [3:0] client_id_i;
   logic [1:0] data_not_reset_i;
   logic [1:0] len_i;
   logic [1:0] payload_i;
   logic [1:0] yumi_o;
   logic       tag_data_o;
   logic       init_done_o;
   logic       busy_o;

   bsg_nonsynth_manycore_tag_sequencer #(
      .num_requesters_p   (2),
      .num_clients_p      (4),
      .max_payload_width_p(1),
      .init_ones_p        (16),
      .init_zeros_p       (16)
   ) dut (
      .clk_i           (clk),
      .reset_i         (reset_i),
      .v_i             (v_i),
      .client_id_i     (client_id_i),
      .data_not_reset_i(data_not_reset_i),
      .len_i           (len_i),
      .payload_i       (payload_i),
      .yumi_o          (yumi_o),
      .tag_data_o      (tag_data_o),
      .init_done_o     (init_done_o),
      .busy_o          (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  onehot;
      int unsigned gap;
   } grant_t;

   typedef struct packed {
      int unsigned nbits;
      logic [15:0] bits;
   } pkt_t;

   grant_t grant_q[$];
   pkt_t   pkt_q[$];

   int unsigned n_pass     = 0;
   int unsigned n_total    = 0;
   int unsigned cyc        = 0;
   int unsigned last_yumi  = 0;
   int unsigned abort_cnt  = 0;
   int unsigned abort_bits = 0;
   logic        dec_active = 1'b0;
   logic        need_gap   = 1'b0;
   logic [15:0] raw        = 16'd0;
   int unsigned nb         = 0;

   function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endfunction

   // Monitor: grant order/spacing and packet deserialization.
   always @(negedge clk) begin
      grant_t      g;
      pkt_t        p;
      int unsigned ln;
      cyc = cyc + 1;
      if (yumi_o != 2'b00) begin
         if (grant_q.size() == 0) begin
            chk("yumi_unexpected", 32'(yumi_o), 0);
         end else begin
            g = grant_q.pop_front();
            chk("yumi_grant", 32'(yumi_o), 32'(g.onehot));
            if (g.gap != 0) chk("yumi_gap", cyc - last_yumi, g.gap);
            chk("yumi_busy", 32'(busy_o), 0);
         end
         last_yumi = cyc;
      end
      if (reset_i || !init_done_o) begin
         if (dec_active) begin
            abort_cnt++;
            abort_bits = nb;
         end
         dec_active = 1'b0;
         need_gap   = 1'b0;
      end else if (dec_active) begin
         raw = raw | (16'(tag_data_o) << nb);
         nb  = nb + 1;
         if (nb >= HDR) begin
            ln = 32'(raw[2+LG_CLIENTS +: LG_LEN]);
            if (nb == HDR + ln) begin
               if (pkt_q.size() == 0) begin
                  chk("pkt_unexpected", nb, 0);
               end else begin
                  p = pkt_q.pop_front();
                  chk("pkt_nbits", nb, p.nbits);
                  chk("pkt_bits", 32'(raw), 32'(p.bits));
               end
               dec_active = 1'b0;
               need_gap   = 1'b1;
            end
         end
      end else if (need_gap) begin
         chk("gap_tag", 32'(tag_data_o), 0);
         chk("gap_busy", 32'(busy_o), 0);
         need_gap = 1'b0;
      end else if (tag_data_o) begin
         dec_active = 1'b1;
         raw        = 16'd1;
         nb         = 1;
      end
   end

   task automatic set_req(input int r, input logic [1:0] id, input logic dnr,
                          input logic ln, input logic pl);
      if (r == 0) begin
         client_id_i[1:0]    = id;
         data_not_reset_i[0] = dnr;
         len_i[0]            = ln;
         payload_i[0]        = pl;
      end else begin
         client_id_i[3:2]    = id;
         data_not_reset_i[1] = dnr;
         len_i[1]            = ln;
         payload_i[1]        = pl;
      end
   endtask

   task automatic wait_yumi(input logic [1:0] onehot);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if ((yumi_o & onehot) != 2'b00) seen = 1'b1;
      end
      if (!seen) chk("yumi_timeout", 32'(yumi_o), 32'(onehot));
   endtask

   task automatic send_one(input int r, input logic [1:0] id, input logic dnr, input logic ln,
                           input logic pl, input int unsigned nbits, input logic [15:0] bits);
      logic [1:0] oh;
      oh = (r == 0) ? 2'b01 : 2'b10;
      grant_q.push_back('{onehot: oh, gap: 0});
      pkt_q.push_back('{nbits: nbits, bits: bits});
      @(posedge clk); #1;
      set_req(r, id, dnr, ln, pl);
      v_i = v_i | oh;
      wait_yumi(oh);
      @(posedge clk); #1;
      v_i = v_i & ~oh;
      repeat (nbits + 2) @(negedge clk);
   endtask

   task automatic check_init();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         chk("init_tag", 32'(tag_data_o), (i < 16) ? 32'd1 : 32'd0);
         if (i == 0 || i == 31) begin
            chk("init_busy", 32'(busy_o), 1);
            chk("init_not_done", 32'(init_done_o), 0);
         end
      end
      @(negedge clk);
      chk("init_done", 32'(init_done_o), 1);
      chk("idle_busy", 32'(busy_o), 0);
      chk("idle_tag", 32'(tag_data_o), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset_i          = 1'b1;
      v_i              = 2'b00;
      client_id_i      = 4'd0;
      data_not_reset_i = 2'b00;
      len_i            = 2'b00;
      payload_i        = 2'b00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tag", 32'(tag_data_o), 0);
      chk("rst_yumi", 32'(yumi_o), 0);
      chk("rst_init_done", 32'(init_done_o), 0);
      chk("rst_busy", 32'(busy_o), 1);
      @(posedge clk); #1;
      reset_i = 1'b0;
      check_init();

      // Data packet: 1, id=2 -> 0,1, dnr 1, len 1, payload 1
      send_one(0, 2'd2, 1'b1, 1'b1, 1'b1, 6, 16'b111101);
      // Client reset packet with len=0: 1,0,0,0,0
      send_one(1, 2'd0, 1'b0, 1'b0, 1'b0, 5, 16'b00001);

      // Round robin with both requesters held: grants 0,1,0,1 spaced by 7
      grant_q.push_back('{onehot: 2'b01, gap: 0});
      grant_q.push_back('{onehot: 2'b10, gap: 7});
      grant_q.push_back('{onehot: 2'b01, gap: 7});
      grant_q.push_back('{onehot: 2'b10, gap: 7});
      pkt_q.push_back('{nbits: 6, bits: 16'b011011});
      pkt_q.push_back('{nbits: 6, bits: 16'b111111});
      pkt_q.push_back('{nbits: 6, bits: 16'b011011});
      pkt_q.push_back('{nbits: 6, bits: 16'b111111});
      @(posedge clk); #1;
      set_req(0, 2'd1, 1'b1, 1'b1, 1'b0);
      set_req(1, 2'd3, 1'b1, 1'b1, 1'b1);
      v_i = 2'b11;
      n = 0;
      for (int i = 0; i < 100 && n < 4; i++) begin
         @(negedge clk);
         if (yumi_o != 2'b00) n++;
      end
      chk("rr_grant_count", 32'(n), 4);
      @(posedge clk); #1;
      v_i = 2'b00;
      repeat (8) @(negedge clk);

      // Reset on the third bit with v_i still held: abort, replay init, re-grant
      grant_q.push_back('{onehot: 2'b01, gap: 0});
      grant_q.push_back('{onehot: 2'b01, gap: 37});
      pkt_q.push_back('{nbits: 6, bits: 16'b111101});
      @(posedge clk); #1;
      set_req(0, 2'd2, 1'b1, 1'b1, 1'b1);
      v_i = 2'b01;
      wait_yumi(2'b01);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_bit1", 32'(tag_data_o), 0);
      @(posedge clk); #1;
      reset_i = 1'b1;
      @(negedge clk);
      chk("abort_tag", 32'(tag_data_o), 0);
      chk("abort_init_done", 32'(init_done_o), 0);
      chk("abort_yumi", 32'(yumi_o), 0);
      chk("abort_busy", 32'(busy_o), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_init_done2", 32'(init_done_o), 0);
      @(posedge clk); #1;
      reset_i = 1'b0;
      check_init();
      @(posedge clk); #1;
      v_i = 2'b00;
      repeat (10) @(negedge clk);

      chk("abort_count", abort_cnt, 1);
      chk("abort_bits", abort_bits, 2);
      chk("grant_q_empty", 32'(grant_q.size()), 0);
      chk("pkt_q_empty", 32'(pkt_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
